truth_table_sequencer: RTL and testbench

//  Sequencer and checker for N_IN-input combinational function realisations.
//  - Drives every input vector 0..2^N_IN-1 in ascending order.
//  - Waits a settle interval, then samples N_DUT parallel implementations of the same function.
//  - Compares all implementations against each other; counts mismatches and records the first failing vector.
//  - Sits between a start/result interface and the gate-level function blocks; replaces hand-written vector stimulus.

---
 rtl/truth_table_sequencer.sv | 171 +++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps every input vector of an N_IN-input function and checks
// that N_DUT parallel implementations agree. Each vector takes SETTLE_CYC+2 cycles.
// No backpressure. An optional tt_word capture of implementation 0 is enabled by TT_CAPTURE_EN.
module truth_table_sequencer #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned N_DUT      = 3,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_DUT-1:0]     dut_y,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic                 first_err_valid,
`ifdef TT_CAPTURE_EN
  output logic [N_IN-1:0]      first_err_vec,
  output logic [2**N_IN-1:0]   tt_word
`else
  output logic [N_IN-1:0]      first_err_vec
`endif
);

  // The settle counter only needs to reach SETTLE_CYC-1. Keep at least one bit so that SETTLE_CYC=0 still elaborates.
  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [N_IN-1:0] VEC_MAX     = '1;
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN:0]     err_q, err_d;
  logic              fvalid_q, fvalid_d;
  logic [N_IN-1:0]   fvec_q, fvec_d;
  logic              done_q, done_d;
`ifdef TT_CAPTURE_EN
  logic [2**N_IN-1:0] tt_q, tt_d;
`endif

  logic mismatch;
  logic start_ok;

  // Implementations disagree unless every sampled output is 1 or every one is 0.
  assign mismatch = !((&dut_y) || !(|dut_y));
  // A start request counts only when the sequencer is not sweeping and abort is not also asserted.
  assign start_ok = start && !abort && (state_q == S_IDLE || state_q == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Abort overrides everything, including a simultaneous start.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) state_d = S_APPLY;
        S_APPLY:        state_d = (SETTLE_CYC == 0) ? S_CHECK : S_SETTLE;
        S_SETTLE:       if (cnt_q == '0) state_d = S_CHECK;
        S_CHECK:        state_d = (vec_q == VEC_MAX) ? S_DONE : S_APPLY;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next-state logic: vector stepping, settle count, error bookkeeping.
  always_comb begin
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    done_d   = done_q;
`ifdef TT_CAPTURE_EN
    tt_d     = tt_q;
`endif
    if (abort) begin
      // Partial error results stay visible after an abort. Only done is dropped.
      done_d = 1'b0;
    end else if (start_ok) begin
      vec_d    = '0;
      err_d    = '0;
      fvalid_d = 1'b0;
      fvec_d   = '0;
      done_d   = 1'b0;
`ifdef TT_CAPTURE_EN
      tt_d     = '0;
`endif
    end else begin
      case (state_q)
        S_APPLY: cnt_d = SETTLE_LOAD;
        S_SETTLE: if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        S_CHECK: begin
          if (mismatch) begin
            err_d = err_q + ERR_ONE;
            if (!fvalid_q) begin
              fvalid_d = 1'b1;
              fvec_d   = vec_q;
            end
          end
`ifdef TT_CAPTURE_EN
          tt_d[vec_q] = dut_y[0];
`endif
          // The vector advances only when leaving CHECK, so it is stable throughout sampling.
          if (vec_q == VEC_MAX) done_d = 1'b1;
          else                  vec_d  = vec_q + VEC_ONE;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers. Reset discards any partial sweep results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
      done_q   <= 1'b0;
`ifdef TT_CAPTURE_EN
      tt_q     <= '0;
`endif
    end else begin
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
      done_q   <= done_d;
`ifdef TT_CAPTURE_EN
      tt_q     <= tt_d;
`endif
    end
  end

  // Output decode. busy follows the state, and pass is qualified by done.
  always_comb begin
    busy            = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    done            = done_q;
    pass            = done_q && (err_q == '0);
    vec_out         = vec_q;
    err_cnt         = err_q;
    first_err_valid = fvalid_q;
    first_err_vec   = fvec_q;
`ifdef TT_CAPTURE_EN
    tt_word         = tt_q;
`endif
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer at its default parameters (4 inputs, 3 implementations, settle of 2).
// The implementations are modelled as 3 copies of 4-input parity, with per-vector fault injection on dut_y[1].
// The tt_word checks are compiled in only when TT_CAPTURE_EN is defined.
module tb_truth_table_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  dut_y;
  logic [3:0]  vec_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_cnt;
  logic        first_err_valid;
  logic [3:0]  first_err_vec;
`ifdef TT_CAPTURE_EN
  logic [15:0] tt_word;
`endif

  logic [15:0] bad_mask;
  int          n_pass;
  int          n_total;

  truth_table_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .dut_y           (dut_y),
    .vec_out         (vec_out),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
`ifdef TT_CAPTURE_EN
    .first_err_vec   (first_err_vec),
    .tt_word         (tt_word)
`else
    .first_err_vec   (first_err_vec)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three identical parity implementations. A set bit in bad_mask inverts implementation 1 at that vector.
  always_comb begin
    dut_y    = {3{^vec_out}};
    dut_y[1] = dut_y[1] ^ bad_mask[vec_out];
  end

  // Accept a start and then check the full 64-cycle sweep: the vector sequence, done timing and final results.
  task automatic run_sweep(input string tag, input logic [4:0] exp_err,
                           input logic exp_fv, input logic [3:0] exp_fvec);
    int seq_bad;
    int early_done;
    seq_bad = 0;
    early_done = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || vec_out !== 4'd0 || done !== 1'b0)
      $display("FAIL %s_start: busy=%b vec=%0d done=%b required busy=1 vec=0 done=0", tag, busy, vec_out, done);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      if (vec_out !== 4'(i / 4) || busy !== 1'b1) seq_bad++;
      if (done !== 1'b0) early_done++;
      @(negedge clk);
    end
    n_total++;
    if (seq_bad != 0 || early_done != 0)
      $display("FAIL %s_seq: bad vector cycles=%0d early done cycles=%0d required 0/0", tag, seq_bad, early_done);
    else n_pass++;
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== (exp_err == 5'd0) || vec_out !== 4'd15)
      $display("FAIL %s_done: done=%b busy=%b pass=%b vec=%0d required 1 0 %b 15",
               tag, done, busy, pass, vec_out, (exp_err == 5'd0));
    else n_pass++;
    n_total++;
    if (err_cnt !== exp_err || first_err_valid !== exp_fv || first_err_vec !== exp_fvec)
      $display("FAIL %s_result: err=%0d fv=%b fvec=%0d required %0d %b %0d",
               tag, err_cnt, first_err_valid, first_err_vec, exp_err, exp_fv, exp_fvec);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bad_mask = '0;
    #12;
    n_total++;
    if ({busy, done, pass, err_cnt, first_err_valid, first_err_vec, vec_out} !== '0)
      $display("FAIL reset_values: outputs=%h required 0",
               {busy, done, pass, err_cnt, first_err_valid, first_err_vec, vec_out});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 4'd0)
      $display("FAIL reset_idle: busy=%b done=%b vec=%0d required 0 0 0", busy, done, vec_out);
    else n_pass++;
  endtask

  task automatic test_clean_sweep();
    bad_mask = '0;
    run_sweep("clean", 5'd0, 1'b0, 4'd0);
  endtask

  task automatic test_mismatch();
    bad_mask = 16'h1020;
    run_sweep("mismatch", 5'd2, 1'b1, 4'd5);
  endtask

  task automatic test_abort();
    int guard;
    bad_mask = 16'h0008;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (vec_out !== 4'd7 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_total++;
    if (guard >= 100) $display("FAIL abort_reach7: vec=%0d required 7 within 100 cycles", vec_out);
    else n_pass++;
    // Drive abort and start together. Abort must take priority.
    abort = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_idle: busy=%b done=%b required 0 0", busy, done);
    else n_pass++;
    n_total++;
    if (err_cnt !== 5'd1 || first_err_valid !== 1'b1 || first_err_vec !== 4'd3)
      $display("FAIL abort_partial: err=%0d fv=%b fvec=%0d required 1 1 3", err_cnt, first_err_valid, first_err_vec);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL abort_stay_idle: busy=%b required 0", busy);
    else n_pass++;
    bad_mask = '0;
    run_sweep("restart", 5'd0, 1'b0, 4'd0);
  endtask

  task automatic test_back_to_back();
    int dbad;
    bad_mask = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dbad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 20) start = 1'b1;
      if (i == 21) start = 1'b0;
      if (vec_out !== 4'(i / 4) || done !== 1'b0) dbad++;
      @(negedge clk);
    end
    n_total++;
    if (dbad != 0) $display("FAIL busy_start_ignored: disturbed cycles=%0d required 0", dbad);
    else n_pass++;
    n_total++;
    if (done !== 1'b1 || pass !== 1'b1)
      $display("FAIL busy_start_done: done=%b pass=%b required 1 1", done, pass);
    else n_pass++;
    run_sweep("rerun", 5'd0, 1'b0, 4'd0);
  endtask

  task automatic test_reset_midsweep();
    bad_mask = 16'h0002;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_total++;
    if (err_cnt !== 5'd1 || busy !== 1'b1)
      $display("FAIL midsweep_pre: err=%0d busy=%b required 1 1", err_cnt, busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, pass, err_cnt, first_err_valid, first_err_vec, vec_out} !== '0)
      $display("FAIL midsweep_async: outputs=%h required 0",
               {busy, done, pass, err_cnt, first_err_valid, first_err_vec, vec_out});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad_mask = '0;
    repeat (5) @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || vec_out !== 4'd0 || done !== 1'b0)
      $display("FAIL midsweep_idle: busy=%b vec=%0d done=%b required 0 0 0", busy, vec_out, done);
    else n_pass++;
  endtask

`ifdef TT_CAPTURE_EN
  task automatic test_tt_capture();
    bad_mask = '0;
    run_sweep("tt", 5'd0, 1'b0, 4'd0);
    n_total++;
    if (tt_word !== 16'h6996) $display("FAIL tt_word: got %h required 6996", tt_word);
    else n_pass++;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (tt_word !== 16'h0000) $display("FAIL tt_clear: got %h required 0000", tt_word);
    else n_pass++;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_clean_sweep();
    test_mismatch();
    test_abort();
    test_back_to_back();
    test_reset_midsweep();
`ifdef TT_CAPTURE_EN
    test_tt_capture();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
